// File: rtl/dut_pat_chk_if.sv
// Purpose: bundles the pattern checker's sample input, counter clear and status outputs.
// Latency: none; this is wiring only.
// Backpressure: none; en_i qualifies samples and there is no ready path.
// Ports: en_i/data_i/clr_cnt_i flow from the lane side (master) into the checker (slave).
//        locked_o/err_data_o/err_state_o/err_cnt_o flow back from the checker.
interface dut_pat_chk_if #(
    parameter int IO_SIZE_G = 4,
    parameter int CNT_W_G   = 16
);
    logic                 en_i;
    logic [IO_SIZE_G-1:0] data_i;
    logic                 clr_cnt_i;
    logic                 locked_o;
    logic                 err_data_o;
    logic                 err_state_o;
    logic [CNT_W_G-1:0]   err_cnt_o;

    modport master (
        output en_i, data_i, clr_cnt_i,
        input  locked_o, err_data_o, err_state_o, err_cnt_o
    );

    modport slave (
        input  en_i, data_i, clr_cnt_i,
        output locked_o, err_data_o, err_state_o, err_cnt_o
    );
endinterface

// File: rtl/dut_pat_chk.sv
// Purpose: locks onto a wrapping 0..LIM count, flags per-sample mismatches and loss of lock.
// Latency: locked_o/err_data_o/err_state_o are registered, valid the cycle after the sampling edge.
// Backpressure: none; samples are taken only when en_i=1 and everything holds otherwise.
// Ports: clk_i, rst_i (sync, active-high) plain; bus (dut_pat_chk_if.slave) carries
//        en_i, data_i, clr_cnt_i in and locked_o, err_data_o, err_state_o, err_cnt_o out.
// Build option: define DUT_PAT_CHK_CNT_EN to build the saturating error counter;
//        without it err_cnt_o is tied to 0 and clr_cnt_i is ignored.
module dut_pat_chk #(
    parameter int IO_SIZE_G  = 4,
    parameter int LIM        = 14,
    parameter int LOCK_CNT_G = 4,
    parameter int LOSS_CNT_G = 3,
    parameter int CNT_W_G    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dut_pat_chk_if.slave  bus
);
    localparam int GW = $clog2(LOCK_CNT_G + 1);
    localparam int BW = $clog2(LOSS_CNT_G + 1);
    localparam logic [IO_SIZE_G-1:0] LIM_V = IO_SIZE_G'(LIM);

    typedef enum logic {ACQ = 1'b0, LOCK = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [IO_SIZE_G-1:0] prev_q, prev_d;
    logic                 seeded_q, seeded_d;
    logic [GW-1:0]        good_q, good_d;
    logic [BW-1:0]        bad_q, bad_d;
    logic                 locked_q, locked_d;
    logic                 err_data_q, err_data_d;
    logic                 err_state_q, err_state_d;

    logic [IO_SIZE_G-1:0] exp_dat;
    logic                 match;

    always_comb begin
        // Expected successor; the +1 wraps naturally in IO_SIZE_G bits.
        exp_dat = (prev_q == LIM_V) ? '0 : prev_q + 1'b1;
        // Out-of-range words never match, even if they equal the wrapped successor.
        match   = (bus.data_i <= LIM_V) && (bus.data_i == exp_dat);

        state_d    = state_q;
        prev_d     = prev_q;
        seeded_d   = seeded_q;
        good_d     = good_q;
        bad_d      = bad_q;
        err_data_d = 1'b0;

        if (bus.en_i) begin
            // The reference always follows the received data, in both states.
            prev_d = bus.data_i;
            case (state_q)
                ACQ: begin
                    if (!seeded_q) begin
                        // First sample after (re)entering ACQ only seeds the reference.
                        seeded_d = 1'b1;
                    end else if (match) begin
                        if (good_q == GW'(LOCK_CNT_G - 1)) begin
                            state_d = LOCK;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_data_d = 1'b1;
                        if (bad_q == BW'(LOSS_CNT_G - 1)) begin
                            state_d  = ACQ;
                            good_d   = '0;
                            bad_d    = '0;
                            seeded_d = 1'b0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                end
                default: state_d = ACQ;
            endcase
        end

        // Status outputs are derived from the next state so they line up with it.
        locked_d    = (state_d == LOCK);
        err_state_d = (state_d != LOCK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACQ;
            prev_q      <= '0;
            seeded_q    <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_data_q  <= 1'b0;
            err_state_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            seeded_q    <= seeded_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_data_q  <= err_data_d;
            err_state_q <= err_state_d;
        end
    end

    assign bus.locked_o    = locked_q;
    assign bus.err_data_o  = err_data_q;
    assign bus.err_state_o = err_state_q;

`ifdef DUT_PAT_CHK_CNT_EN
    logic [CNT_W_G-1:0] cnt_q, cnt_d;

    // Counts visible err_data_o pulses; a clear wins over a coincident pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt_i) begin
            cnt_d = '0;
        end else if (err_data_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.err_cnt_o = cnt_q;
`else
    logic unused_clr;
    assign unused_clr    = bus.clr_cnt_i;
    assign bus.err_cnt_o = '0;
`endif
endmodule
